serv_rf_serial_resp: RTL and testbench
======================================

// Module: serv_rf_serial_resp
// PURPOSE
// - Responder end of the core's bit-serial register-file interface: answers
//   o_rf_rreq/o_rf_wreq with a ready pulse and streams two operands LSB-first.
// - Accepts two serial write ports.
// - Flop-based store of 32 GPRs plus 4 CSR slots (WITH_CSR=1).
// - Sits directly on the core's RF port; no external RAM.
// PARAMETERS
// - WITH_CSR  1  1: 36 words, 6-bit addresses (32..35 = CSR slots); 0: 32 words, 5-bit
// PORTS
// - clk       in   1           rising-edge clock
// - i_rst     in   1           synchronous active-high reset
// - i_rreq    in   1           read request; i_rreg0/1 sampled this cycle
// - i_wreq    in   1           write request (no read data follows)
// - o_ready   out  1           one-cycle acknowledge of a request
// - i_rreg0   in   5+WITH_CSR  read address, port 0 (rs1/CSR)
// - i_rreg1   in   5+WITH_CSR  read address, port 1 (rs2)
// - o_rdata0  out  1           serial read data, port 0
// - o_rdata1  out  1           serial read data, port 1
// - i_wreg0   in   5+WITH_CSR  write address, port 0 (rd)
// - i_wreg1   in   5+WITH_CSR  write address, port 1 (CSR/trap)
// - i_wen0    in   1           write-bit strobe, port 0
// - i_wen1    in   1           write-bit strobe, port 1
// - i_wdata0  in   1           serial write data, port 0
// - i_wdata1  in   1           serial write data, port 1
// BEHAVIOUR
// - Reset: o_ready=0, o_rdata0/1=0, read and write bit counters=0, FSM=IDLE.
//   Register contents are kept unless SERV_RF_RESP_CLEAR_EN is defined.
// - FSM states: IDLE, ACK, STREAM.
// - IDLE: i_rreq|i_wreq at cycle T latches i_rreg0/1, zeroes both write counters,
//   goes to ACK. If both requests are high, this is one request and gives one ready.
// - ACK (T+1): o_ready=1 for exactly one cycle.
//   - From an rreq: go to STREAM.
//   - From a wreq only: go to IDLE.
// - STREAM: o_rdata0/1 carry bit n of the latched words in cycle T+2+n, n=0..31.
//   - Read counter 5 bits; at n=31 wrap to 0 and go to IDLE.
//   - Outside STREAM, o_rdata0/1=0.
// - Read latency: request to bit 0 = 2 cycles; request to ready = 1 cycle.
// - A new rreq/wreq in ACK or STREAM is a restart: relatch, zero counters, go to ACK.
// - Writes: each cycle i_wenX=1, i_wdataX goes to bit wcntX of word i_wregX.
//   - wcntX then increments, mod 32.
//   - Writes are accepted in any state, independent of the read FSM.
// - Address 0 is hardwired zero: writes are dropped, reads return 0.
// - Both ports write the same word and same bit in the same cycle: port 0 wins.
// - Read/write collision on one word: bits written in earlier cycles are visible
//   to the stream. A bit written in the cycle it is streamed shows the old value.
// - Out-of-range address (WITH_CSR=0 has none; WITH_CSR=1 uses 36..63):
//   - writes are dropped;
//   - reads return 0.
// - Reset asserted mid-STREAM or mid-write:
//   - stream aborts in the next cycle;
//   - bits already written stay written.
// CONFIGURATION
// - SERV_RF_RESP_CLEAR_EN defined: i_rst also clears all words to 0.
//   Reset must be held >=1 cycle; the clear completes in that cycle.
// - SERV_RF_RESP_CLEAR_EN undefined: no reset on the storage array.
//   Contents are X/initial until written. Intended for FPGA flop-RAM inference.
// TESTING
// - Write x5: 32 cycles of i_wen0=1, i_wreg0=5, data 0xDEADBEEF LSB-first.
//   Then rreq with rreg0=5, rreg1=0.
//   -> o_ready at T+1; o_rdata0 gives 0xDEADBEEF over T+2..T+33; o_rdata1 all 0.
// - Write 0xFFFFFFFF to x0, then read rreg0=0 -> 32 zero bits. Write has no effect.
// - WITH_CSR=1: port1 writes 0x00000080 to addr 33 while port0 writes 0x12345678 to x1.
//   Read rreg0=33, rreg1=1 -> 0x00000080 and 0x12345678.
// - i_rreq=i_wreq=1 in the same cycle -> exactly one o_ready pulse, stream follows.
// - i_rreq re-asserted at stream bit 10 -> o_ready one cycle later.
//   Stream restarts at bit 0, two cycles after the rreq.
// - i_rst at stream bit 7 -> o_rdata0/1=0 and FSM IDLE in the next cycle.
//   - CLEAR_EN defined: a subsequent read of x5 = 0.
//   - CLEAR_EN undefined: it returns 0xDEADBEEF.

Source files
------------

// File: rtl/serv_rf_serial_resp.sv
// serv_rf_serial_resp
// Responder end of the core's bit-serial register-file port. It holds 32 GPRs
// (plus 4 CSR slots when WITH_CSR=1) in flops. After each rreq/wreq it gives a
// one-cycle ready pulse. After an rreq it then streams the two addressed words
// LSB-first. The two serial write ports run independently of the read FSM.
//
// Optional feature: define SERV_RF_RESP_CLEAR_EN to make i_rst also clear the
// storage array. When it is undefined the array has no reset, so the storage
// can map onto FPGA flop-RAM.
module serv_rf_serial_resp #(
  parameter int WITH_CSR = 1
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic                i_rreq,
  input  logic                i_wreq,
  output logic                o_ready,
  input  logic [4+WITH_CSR:0] i_rreg0,
  input  logic [4+WITH_CSR:0] i_rreg1,
  output logic                o_rdata0,
  output logic                o_rdata1,
  input  logic [4+WITH_CSR:0] i_wreg0,
  input  logic [4+WITH_CSR:0] i_wreg1,
  input  logic                i_wen0,
  input  logic                i_wen1,
  input  logic                i_wdata0,
  input  logic                i_wdata1
);

  localparam int AW     = 5 + WITH_CSR;
  localparam int NWORDS = (WITH_CSR != 0) ? 36 : 32;

  typedef enum logic [1:0] {IDLE, ACK, STREAM} state_e;

  state_e        state_q, state_d;
  logic [4:0]    rcnt_q, rcnt_d;
  logic [AW-1:0] rreg0_q, rreg0_d;
  logic [AW-1:0] rreg1_q, rreg1_d;
  logic          rd_req_q, rd_req_d;
  logic          ready_q, ready_d;
  logic [4:0]    wcnt0_q, wcnt0_d;
  logic [4:0]    wcnt1_q, wcnt1_d;
  logic [31:0]   mem_q [NWORDS];
  logic [31:0]   mem_d [NWORDS];
  logic          req;

  // x0 is hardwired zero. Addresses past the last CSR slot do not exist.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NWORDS);
  endfunction

  assign req = i_rreq | i_wreq;

  // Read FSM next state. Any request, in any state, restarts at ACK.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    rreg0_d  = rreg0_q;
    rreg1_d  = rreg1_q;
    rd_req_d = rd_req_q;
    ready_d  = 1'b0;
    if (req) begin
      state_d  = ACK;
      rreg0_d  = i_rreg0;
      rreg1_d  = i_rreg1;
      rd_req_d = i_rreq;
      rcnt_d   = '0;
      ready_d  = 1'b1;
    end else begin
      case (state_q)
        ACK: begin
          rcnt_d  = '0;
          state_d = rd_req_q ? STREAM : IDLE;
        end
        STREAM: begin
          rcnt_d = rcnt_q + 5'd1;
          if (rcnt_q == 5'd31) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Write bit counters. A request rezeroes them. That takes priority over a
  // strobe in the same cycle.
  always_comb begin
    wcnt0_d = wcnt0_q;
    wcnt1_d = wcnt1_q;
    if (i_wen0) wcnt0_d = wcnt0_q + 5'd1;
    if (i_wen1) wcnt1_d = wcnt1_q + 5'd1;
    if (req) begin
      wcnt0_d = '0;
      wcnt1_d = '0;
    end
  end

  // Storage update. Port 0 is applied last, so it wins a same-bit collision.
  always_comb begin
    for (int i = 0; i < NWORDS; i++) mem_d[i] = mem_q[i];
    if (i_wen1 && addr_ok(i_wreg1)) mem_d[i_wreg1][wcnt1_q] = i_wdata1;
    if (i_wen0 && addr_ok(i_wreg0)) mem_d[i_wreg0][wcnt0_q] = i_wdata0;
  end

  // Control registers: FSM, read counter, latched addresses, ready, write counters.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      rreg0_q  <= '0;
      rreg1_q  <= '0;
      rd_req_q <= 1'b0;
      ready_q  <= 1'b0;
      wcnt0_q  <= '0;
      wcnt1_q  <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      rreg0_q  <= rreg0_d;
      rreg1_q  <= rreg1_d;
      rd_req_q <= rd_req_d;
      ready_q  <= ready_d;
      wcnt0_q  <= wcnt0_d;
      wcnt1_q  <= wcnt1_d;
    end
  end

`ifdef SERV_RF_RESP_CLEAR_EN
  // Storage array. Reset wipes every word in one cycle.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < NWORDS; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < NWORDS; i++) mem_q[i] <= mem_d[i];
    end
  end
`else
  // Storage array. There is no reset, so it can infer as flop-RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NWORDS; i++) mem_q[i] <= mem_d[i];
  end
`endif

  // Stream data is read straight from the array. A bit written in an earlier
  // cycle is therefore visible. A bit written in the cycle it is streamed still
  // shows the old value.
  always_comb begin
    o_rdata0 = 1'b0;
    o_rdata1 = 1'b0;
    if (state_q == STREAM) begin
      if (addr_ok(rreg0_q)) o_rdata0 = mem_q[rreg0_q][rcnt_q];
      if (addr_ok(rreg1_q)) o_rdata1 = mem_q[rreg1_q][rcnt_q];
    end
  end

  assign o_ready = ready_q;

endmodule

// File: tb/tb_serv_rf_serial_resp.sv
// tb_serv_rf_serial_resp
// Random and directed stimulus for the WITH_CSR=1 responder. The reference
// model is a plain word array. It is updated whole-word after each write burst
// and read back as the expected stream word.
module tb_serv_rf_serial_resp;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_rreq = 1'b0, i_wreq = 1'b0;
  logic       o_ready, o_rdata0, o_rdata1;
  logic [5:0] i_rreg0 = '0, i_rreg1 = '0, i_wreg0 = '0, i_wreg1 = '0;
  logic       i_wen0 = 1'b0, i_wen1 = 1'b0, i_wdata0 = 1'b0, i_wdata1 = 1'b0;

  logic [31:0] model [64];
  int n_chk = 0;
  int n_pass = 0;

  serv_rf_serial_resp #(.WITH_CSR(1)) dut (
    .clk(clk), .i_rst(i_rst), .i_rreq(i_rreq), .i_wreq(i_wreq), .o_ready(o_ready),
    .i_rreg0(i_rreg0), .i_rreg1(i_rreg1), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
    .i_wreg0(i_wreg0), .i_wreg1(i_wreg1), .i_wen0(i_wen0), .i_wen1(i_wen1),
    .i_wdata0(i_wdata0), .i_wdata1(i_wdata1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_word(input logic [5:0] a);
    return (a != 6'd0 && a < 6'd36) ? model[a] : 32'd0;
  endfunction

  // wreq, then 32 serial bits on each enabled port.
  task automatic wr(input logic e0, input logic [5:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [5:0] a1, input logic [31:0] d1);
    i_wreq = 1'b1;
    tick;
    i_wreq = 1'b0;
    chk("wr_ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < 32; k++) begin
      i_wen0 = e0; i_wreg0 = a0; i_wdata0 = d0[k];
      i_wen1 = e1; i_wreg1 = a1; i_wdata1 = d1[k];
      tick;
    end
    i_wen0 = 1'b0; i_wen1 = 1'b0;
    if (e1 && a1 != 6'd0 && a1 < 6'd36) model[a1] = d1;
    if (e0 && a0 != 6'd0 && a0 < 6'd36) model[a0] = d0;
  endtask

  // Full read. Checks a single ready pulse, collects both streams, then checks idle.
  task automatic rd(input logic [5:0] a0, input logic [5:0] a1, input logic also_wreq,
                    output logic [31:0] g0, output logic [31:0] g1);
    logic extra;
    extra = 1'b0;
    i_rreg0 = a0; i_rreg1 = a1; i_rreq = 1'b1; i_wreq = also_wreq;
    tick;
    i_rreq = 1'b0; i_wreq = 1'b0;
    chk("rd_ready", 32'(o_ready), 32'd1);
    for (int k = 0; k < 32; k++) begin
      tick;
      g0[k] = o_rdata0;
      g1[k] = o_rdata1;
      extra = extra | o_ready;
    end
    chk("rd_ready_once", 32'(extra), 32'd0);
    tick;
    chk("rd_idle", 32'({o_ready, o_rdata0, o_rdata1}), 32'd0);
  endtask

  initial begin
    logic [31:0] g0, g1, nw, old;
    logic [5:0]  a0, a1, r0, r1;
    logic [31:0] d0, d1;
    logic        e0, e1;

    for (int i = 0; i < 64; i++) model[i] = 32'd0;

    // Reset state
    tick; tick;
    i_rst = 1'b0;
    tick;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_rdata", 32'({o_rdata0, o_rdata1}), 32'd0);

    // Give every real word a known value, two words per burst.
    for (int a = 1; a < 36; a += 2)
      wr(1'b1, 6'(a), $urandom, (a + 1 < 36), 6'(a + 1), $urandom);

    // x5 = DEADBEEF
    wr(1'b1, 6'd5, 32'hDEADBEEF, 1'b0, 6'd0, 32'd0);
    rd(6'd5, 6'd0, 1'b0, g0, g1);
    chk("x5_rdata0", g0, 32'hDEADBEEF);
    chk("x5_rdata1_x0", g1, 32'd0);

    // x0 stays zero
    wr(1'b1, 6'd0, 32'hFFFFFFFF, 1'b0, 6'd0, 32'd0);
    rd(6'd0, 6'd0, 1'b0, g0, g1);
    chk("x0_read", g0, 32'd0);

    // CSR slot and GPR written together on the two ports
    wr(1'b1, 6'd1, 32'h12345678, 1'b1, 6'd33, 32'h00000080);
    rd(6'd33, 6'd1, 1'b0, g0, g1);
    chk("csr33", g0, 32'h00000080);
    chk("x1", g1, 32'h12345678);

    // Out of range: write dropped, read 0, no alias onto x18
    old = model[18];
    wr(1'b1, 6'd50, 32'hA5A5A5A5, 1'b1, 6'd40, 32'h5A5A5A5A);
    rd(6'd50, 6'd18, 1'b0, g0, g1);
    chk("oor_read", g0, 32'd0);
    chk("oor_no_alias", g1, old);

    // Same word and bit on both ports: port 0 wins
    wr(1'b1, 6'd12, 32'h0F0F1234, 1'b1, 6'd12, 32'hFFFF0000);
    rd(6'd12, 6'd35, 1'b0, g0, g1);
    chk("port0_wins", g0, 32'h0F0F1234);
    chk("csr35", g1, exp_word(6'd35));

    // rreq and wreq together give one ready, and the stream follows
    rd(6'd5, 6'd1, 1'b1, g0, g1);
    chk("both_req_d0", g0, 32'hDEADBEEF);
    chk("both_req_d1", g1, 32'h12345678);

    // Restart at bit 10
    i_rreg0 = 6'd5; i_rreg1 = 6'd0; i_rreq = 1'b1;
    tick;
    i_rreq = 1'b0;
    g0 = '0;
    for (int k = 0; k < 11; k++) begin
      tick;
      g0[k] = o_rdata0;
    end
    chk("pre_restart_bits", 32'(g0[10:0]), 32'(32'hDEADBEEF & 32'h7FF));
    i_rreg0 = 6'd1; i_rreq = 1'b1;
    tick;
    i_rreq = 1'b0;
    chk("restart_ready", 32'({o_ready, o_rdata0}), 32'd2);
    for (int k = 0; k < 32; k++) begin
      tick;
      g0[k] = o_rdata0;
    end
    chk("restart_word", g0, 32'h12345678);
    tick;
    chk("restart_idle", 32'({o_ready, o_rdata0}), 32'd0);

    // Collision: every bit is written one cycle before it streams, so all are visible
    nw = $urandom;
    i_rreg0 = 6'd9; i_rreg1 = 6'd0; i_rreq = 1'b1;
    tick;
    i_rreq = 1'b0;
    for (int k = 0; k < 32; k++) begin
      i_wen0 = 1'b1; i_wreg0 = 6'd9; i_wdata0 = nw[k];
      tick;
      g0[k] = o_rdata0;
    end
    i_wen0 = 1'b0;
    model[9] = nw;
    chk("coll_early_visible", g0, nw);
    tick;

    // Collision: every bit is written in the cycle it streams, so the stream shows the old word
    old = model[9];
    nw = ~old ^ 32'h00FF00FF;
    i_rreq = 1'b1;
    tick;
    i_rreq = 1'b0;
    tick;
    for (int k = 0; k < 32; k++) begin
      g0[k] = o_rdata0;
      i_wen0 = 1'b1; i_wreg0 = 6'd9; i_wdata0 = nw[k];
      tick;
    end
    i_wen0 = 1'b0;
    model[9] = nw;
    chk("coll_same_cycle_old", g0, old);
    tick;
    rd(6'd9, 6'd0, 1'b0, g0, g1);
    chk("coll_after", g0, nw);

    // Randomized write bursts and reads
    for (int r = 0; r < 25; r++) begin
      a0 = 6'($urandom_range(0, 63));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 6'($urandom_range(0, 63));
      d0 = $urandom; d1 = $urandom;
      e0 = 1'($urandom_range(0, 1)); e1 = 1'($urandom_range(0, 1));
      wr(e0, a0, d0, e1, a1, d1);
      r0 = ($urandom_range(0, 1) == 0) ? a0 : 6'($urandom_range(0, 40));
      r1 = ($urandom_range(0, 1) == 0) ? a1 : 6'($urandom_range(0, 40));
      rd(r0, r1, 1'($urandom_range(0, 1)), g0, g1);
      chk("rand_d0", g0, exp_word(r0));
      chk("rand_d1", g1, exp_word(r1));
    end

    // Reset at stream bit 7 aborts the stream
    i_rreg0 = 6'd5; i_rreg1 = 6'd5; i_rreq = 1'b1;
    tick;
    i_rreq = 1'b0;
    for (int k = 0; k < 8; k++) tick;
    chk("pre_rst_bit7", 32'({o_rdata0, o_rdata1}), 32'd3);
    i_rst = 1'b1;
    tick;
    i_rst = 1'b0;
    chk("rst_abort", 32'({o_ready, o_rdata0, o_rdata1}), 32'd0);
    tick;
    chk("rst_stay_idle", 32'({o_ready, o_rdata0, o_rdata1}), 32'd0);
`ifdef SERV_RF_RESP_CLEAR_EN
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
`endif
    rd(6'd5, 6'd1, 1'b0, g0, g1);
    chk("post_rst_x5", g0, exp_word(6'd5));
    chk("post_rst_x1", g1, exp_word(6'd1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
